// File: rtl/video_text.sv
// video_text: text-mode pixel renderer fed by the video timing generator.
// Ports: clock/reset (async, active-low); x/y/hde/vde/hsync/vsync timing in;
//   text_addr/text_data to the text RAM; font_addr/font_data to the font ROM;
//   cursor_x/cursor_y/cursor_en; color/de/hsync_o/vsync_o out, 5 clocks late.
module video_text #(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int BLINK = 4,
    parameter int HW    = 10,
    parameter int VW    = 10,
    parameter int AW    = $clog2(COLS * ROWS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [HW-1:0] x,
    input  logic [VW-1:0] y,
    input  logic          hde,
    input  logic          vde,
    input  logic          hsync,
    input  logic          vsync,
    output logic [AW-1:0] text_addr,
    input  logic [15:0]   text_data,
    output logic [11:0]   font_addr,
    input  logic [7:0]    font_data,
    input  logic [6:0]    cursor_x,
    input  logic [4:0]    cursor_y,
    input  logic          cursor_en,
    output logic [3:0]    color,
    output logic          de,
    output logic          hsync_o,
    output logic          vsync_o
);

    logic [HW-4:0] col;
    logic [VW-5:0] row;
    logic [3:0]    glyph_row;
    logic [2:0]    xsub;

    assign col       = x[HW-1:3];
    assign row       = y[VW-1:4];
    assign glyph_row = y[3:0];
    assign xsub      = x[2:0];

    // Linear cell index; off-screen values are harmless since de is 0 there.
    logic [31:0]   lin_addr;
    logic [AW-1:0] text_addr_d, text_addr_q;

    assign lin_addr    = 32'(row) * 32'(COLS) + 32'(col);
    assign text_addr_d = lin_addr[AW-1:0];

    // Frame counter advances on vsync rising edge; its top bit is the blink
    // phase, so the cursor can only toggle between frames.
    logic [BLINK:0] frame_d, frame_q;
    logic           vs_prev_q;
    logic           vs_rise;

    assign vs_rise = vsync & ~vs_prev_q;
    assign frame_d = vs_rise ? frame_q + 1'b1 : frame_q;

    // Hit uses the phase held before any increment in this same cycle.
    logic hit_d;
    assign hit_d = cursor_en
                 & (32'(col) == 32'(cursor_x))
                 & (32'(row) == 32'(cursor_y))
                 & (glyph_row >= 4'd14)
                 & frame_q[BLINK];

    // Matched delay lines; index 0 is the stage right after sampling.
    logic [3:0][2:0] xsub_q;
    logic [1:0][3:0] grow_q;
    logic [3:0]      de_q;
    logic [3:0]      hs_q;
    logic [3:0]      vs_q;
    logic [3:0]      hit_q;

    // Attribute byte is latched with the font fetch, then held one more
    // stage so it lines up with the ROM output.
    logic [11:0] font_addr_d, font_addr_q;
    logic [7:0]  attr2_q;
    logic [7:0]  attr3_q;

    assign font_addr_d = {text_data[7:0], grow_q[1]};

    logic       pix;
    logic [3:0] color_d, color_q;
    logic       de_out_q, hs_out_q, vs_out_q;

    always_comb begin
        pix     = font_data[3'd7 - xsub_q[3]] | hit_q[3];
        color_d = 4'd0;
        if (de_q[3]) begin
            color_d = pix ? attr3_q[3:0] : attr3_q[7:4];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            text_addr_q <= '0;
            font_addr_q <= '0;
            attr2_q     <= '0;
            attr3_q     <= '0;
            xsub_q      <= '0;
            grow_q      <= '0;
            de_q        <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
            hit_q       <= '0;
            frame_q     <= '0;
            vs_prev_q   <= 1'b0;
            color_q     <= '0;
            de_out_q    <= 1'b0;
            hs_out_q    <= 1'b0;
            vs_out_q    <= 1'b0;
        end else begin
            text_addr_q <= text_addr_d;
            font_addr_q <= font_addr_d;
            attr2_q     <= text_data[15:8];
            attr3_q     <= attr2_q;
            xsub_q      <= {xsub_q[2:0], xsub};
            grow_q      <= {grow_q[0], glyph_row};
            de_q        <= {de_q[2:0], hde & vde};
            hs_q        <= {hs_q[2:0], hsync};
            vs_q        <= {vs_q[2:0], vsync};
            hit_q       <= {hit_q[2:0], hit_d};
            frame_q     <= frame_d;
            vs_prev_q   <= vsync;
            color_q     <= color_d;
            de_out_q    <= de_q[3];
            hs_out_q    <= hs_q[3];
            vs_out_q    <= vs_q[3];
        end
    end

    assign text_addr = text_addr_q;
    assign font_addr = font_addr_q;
    assign color     = color_q;
    assign de        = de_out_q;
    assign hsync_o   = hs_out_q;
    assign vsync_o   = vs_out_q;

endmodule

// File: tb/tb_video_text.sv
// tb_video_text: scoreboard bench for video_text with text RAM / font ROM
// models; expected outputs queued at drive time, popped as the DUT emits.
module tb_video_text;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        hde, vde, hsync, vsync;
    logic [11:0] text_addr;
    logic [15:0] text_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        cursor_en;
    logic [3:0]  color;
    logic        de, hsync_o, vsync_o;

    always #5 clock = ~clock;

    video_text dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .hde       (hde),
        .vde       (vde),
        .hsync     (hsync),
        .vsync     (vsync),
        .text_addr (text_addr),
        .text_data (text_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .cursor_en (cursor_en),
        .color     (color),
        .de        (de),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o)
    );

    logic [15:0] ram [4096];
    logic [7:0]  rom [4096];

    always @(posedge clock) begin
        text_data <= ram[text_addr];
        font_data <= rom[font_addr];
    end

    typedef struct {
        bit          v;
        logic [15:0] val;
    } ent_t;

    ent_t out_q[$];
    ent_t ta_q[$];
    ent_t fa_q[$];

    int       nchk = 0;
    int       nerr = 0;
    logic [4:0] mcnt;
    logic     mprev;
    logic     cen;
    logic [6:0] cx;
    logic [4:0] cy;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        ent_t e;
        if (out_q.size() == 0) chk("out_q_empty", 1, 0);
        else begin
            e = out_q.pop_front();
            chk("out{de,hs,vs,color}", 32'({de, hsync_o, vsync_o, color}),
                32'(e.val));
        end
        if (ta_q.size() == 0) chk("ta_q_empty", 1, 0);
        else begin
            e = ta_q.pop_front();
            if (e.v) chk("text_addr", 32'(text_addr), 32'(e.val));
        end
        if (fa_q.size() == 0) chk("fa_q_empty", 1, 0);
        else begin
            e = fa_q.pop_front();
            if (e.v) chk("font_addr", 32'(font_addr), 32'(e.val));
        end
    endtask

    task automatic drive_push(input logic [9:0] xi, input logic [9:0] yi,
                              input logic hd, input logic vd,
                              input logic hs, input logic vs,
                              input int fcol, input int fta);
        int          col, row;
        logic [3:0]  gr;
        logic [2:0]  xs;
        logic [11:0] ta;
        logic [15:0] td;
        logic [11:0] fa;
        logic [7:0]  fd;
        bit          hit, pix;
        logic [3:0]  c;
        ent_t        e;
        x = xi; y = yi; hde = hd; vde = vd; hsync = hs; vsync = vs;
        cursor_en = cen; cursor_x = cx; cursor_y = cy;
        col = int'(xi) >> 3;
        row = int'(yi) >> 4;
        gr  = yi[3:0];
        xs  = xi[2:0];
        ta  = 12'((row * 80 + col) % 4096);
        td  = ram[ta];
        fa  = {td[7:0], gr};
        fd  = rom[fa];
        hit = cen && col == int'(cx) && row == int'(cy) && gr >= 14 && mcnt[4];
        pix = fd[7 - xs] || hit;
        c   = (hd && vd) ? (pix ? td[11:8] : td[15:12]) : 4'd0;
        if (fcol >= 0) c = fcol[3:0];
        e.v = 1; e.val = {9'd0, hd & vd, hs, vs, c};
        out_q.push_back(e);
        e.v = 1; e.val = (fta >= 0) ? 16'(fta) : 16'(ta);
        ta_q.push_back(e);
        e.v = 1; e.val = 16'(fa);
        fa_q.push_back(e);
        if (vs && !mprev) mcnt = mcnt + 1'b1;
        mprev = vs;
    endtask

    task automatic step(input logic [9:0] xi, input logic [9:0] yi,
                        input logic hd, input logic vd,
                        input logic hs, input logic vs,
                        input int fcol = -1, input int fta = -1);
        @(negedge clock);
        check_outs();
        drive_push(xi, yi, hd, vd, hs, vs, fcol, fta);
    endtask

    task automatic rst_release(input logic [9:0] xi, input logic [9:0] yi,
                               input int fcol, input int fta);
        ent_t e;
        @(negedge clock);
        chk("rst_color", 32'(color), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_hsync_o", 32'(hsync_o), 0);
        chk("rst_vsync_o", 32'(vsync_o), 0);
        chk("rst_text_addr", 32'(text_addr), 0);
        chk("rst_font_addr", 32'(font_addr), 0);
        reset = 1'b1;
        out_q.delete(); ta_q.delete(); fa_q.delete();
        e.v = 1; e.val = '0;
        repeat (4) out_q.push_back(e);
        e.v = 0;
        repeat (2) fa_q.push_back(e);
        mcnt = '0; mprev = 1'b0;
        drive_push(xi, yi, 1'b1, 1'b1, 1'b0, 1'b0, fcol, fta);
    endtask

    task automatic pulse_vs(input int n);
        for (int i = 0; i < n; i++) begin
            step(10'd0, 10'd500, 1'b0, 1'b0, 1'b0, 1'b1);
            step(10'd0, 10'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(10'd0, 10'd500, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Cursor box pixels (x 24..31, y 46..47) get a fixed expectation.
    task automatic draw_cursor_area(input int cur_col);
        for (int yy = 44; yy < 48; yy++)
            for (int xx = 16; xx < 40; xx++) begin
                if (xx >= 24 && xx < 32 && yy >= 46)
                    step(10'(xx), 10'(yy), 1'b1, 1'b1, 1'b0, 1'b0, cur_col);
                else
                    step(10'(xx), 10'(yy), 1'b1, 1'b1, 1'b0, 1'b0);
            end
    endtask

    initial begin
        int exp_a [8];
        exp_a = '{1, 1, 1, 15, 15, 1, 1, 1};
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 16'($urandom);
            rom[i] = 8'($urandom);
        end
        ram[0]     = 16'h1F41;
        rom[12'h410] = 8'h18;
        ram[2399]  = 16'h3C55;
        for (int i = 800; i < 808; i++) ram[i] = 16'hFFFF;
        for (int i = 0; i < 16; i++) rom[12'hFF0 + i] = 8'hFF;
        ram[163]   = 16'h5A20;
        rom[12'h20E] = 8'h00;
        rom[12'h20F] = 8'h00;

        cen = 0; cx = '0; cy = '0;
        x = '0; y = '0; hde = 0; vde = 0; hsync = 0; vsync = 0;
        cursor_en = 0; cursor_x = '0; cursor_y = '0;
        mcnt = '0; mprev = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);

        // First cell: char 'A', fg 15, bg 1, glyph row 0x18
        rst_release(10'd0, 10'd0, exp_a[0], 0);
        for (int i = 1; i < 8; i++)
            step(10'(i), 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, exp_a[i]);
        step(10'd639, 10'd479, 1'b1, 1'b1, 1'b0, 1'b0, -1, 2399);
        idle(6);

        // Blanked pixels over all-ones RAM/ROM
        for (int i = 0; i < 64; i++)
            step(10'(i), 10'd160, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle(6);

        // Scattered pixels
        for (int i = 0; i < 200; i++)
            step(10'($urandom_range(639)), 10'($urandom_range(479)),
                 1'($urandom_range(3) != 0), 1'b1, 1'b0, 1'b0);
        idle(6);

        // Cursor at (3,2): phase 0 shows bg, phase 1 shows fg
        cen = 1; cx = 7'd3; cy = 5'd2;
        draw_cursor_area(5);
        pulse_vs(15);
        step(10'd24, 10'd46, 1'b1, 1'b1, 1'b0, 1'b1, 5);
        step(10'd25, 10'd46, 1'b1, 1'b1, 1'b0, 1'b1, 10);
        step(10'd26, 10'd46, 1'b1, 1'b1, 1'b0, 1'b0, 10);
        draw_cursor_area(10);
        pulse_vs(16);
        draw_cursor_area(5);
        idle(6);

        // Sync waveforms: 96-clock hsync per 128-clock line, 2-line vsync
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 128; i++)
                step(10'(i), 10'(l), 1'b0, 1'b0, 1'(i < 96), 1'(l < 2));
        pulse_vs(15);

        // Mid-line reset while the cursor is lit; counter must restart
        for (int xx = 24; xx < 32; xx++)
            step(10'(xx), 10'd46, 1'b1, 1'b1, 1'b0, 1'b0, 10);
        #2 reset = 1'b0;
        #1;
        chk("async_color", 32'(color), 0);
        chk("async_de", 32'(de), 0);
        chk("async_hsync_o", 32'(hsync_o), 0);
        chk("async_vsync_o", 32'(vsync_o), 0);
        chk("async_text_addr", 32'(text_addr), 0);
        chk("async_font_addr", 32'(font_addr), 0);
        repeat (3) @(posedge clock);
        rst_release(10'd24, 10'd46, 5, 163);
        draw_cursor_area(5);
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
